// File: rtl/secuencia_generador_pkg.sv
// rtl/secuencia_generador_pkg.sv - shared defaults for the serial pattern generator
package secuencia_generador_pkg;

  localparam int SG_WIDTH = 8;
  localparam int SG_LEN_W = 4;
  localparam int SG_DIV_W = 16;

endpackage

// File: rtl/secuencia_generador_if.sv
// rtl/secuencia_generador_if.sv - host-side bundle of the serial pattern generator
interface secuencia_generador_if
  import secuencia_generador_pkg::*;
#(
  parameter int WIDTH = SG_WIDTH,
  parameter int LEN_W = SG_LEN_W,
  parameter int DIV_W = SG_DIV_W
) ();

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [DIV_W-1:0] div;
  logic             w;
  logic             bit_strobe;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, div,
    input  w, bit_strobe, busy, done
  );

  modport slave (
    input  start, pattern, len, div,
    output w, bit_strobe, busy, done
  );

endinterface

// File: rtl/secuencia_generador_divisor_tick.sv
// rtl/secuencia_generador_divisor_tick.sv - 0..term counter with a tick at terminal count
// Equality compare on the terminal value, so an all-ones term never wraps early.
module divisor_tick #(
  parameter int N_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic [N_W-1:0] term,
  output logic           tick
);

  logic [N_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == term) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/secuencia_generador.sv
// rtl/secuencia_generador.sv - MSB-first serial pattern generator with programmable bit period
module secuencia_generador
  import secuencia_generador_pkg::*;
#(
  parameter int WIDTH = SG_WIDTH,
  parameter int LEN_W = SG_LEN_W,
  parameter int DIV_W = SG_DIV_W
) (
  input  logic                  clk,
  input  logic                  reset,
  secuencia_generador_if.slave  sif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_SEND    = SEND,
    S_FINISH  = FINISH,
    S_ILLEGAL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_load, sr_next;
  logic [LEN_W-1:0] bits_q, bits_d, len_c;
  logic [DIV_W-1:0] div_q, div_d;
  logic             w_q, w_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, tick;

  divisor_tick #(.N_W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (div_q),
    .tick  (tick)
  );

  // Left-align the frame so the first bit always sits at the shift register MSB.
  assign len_c   = (sif.len > WIDTH_L) ? WIDTH_L : sif.len;
  assign sr_load = sif.pattern << (WIDTH_L - len_c);
  assign sr_next = sr_q << 1;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bits_d   = bits_q;
    div_d    = div_q;
    w_d      = 1'b0;
    strobe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          busy_d = 1'b1;
          if (len_c != '0) begin
            state_d  = S_SEND;
            sr_d     = sr_load;
            bits_d   = len_c;
            div_d    = sif.div;
            w_d      = sr_load[WIDTH-1];
            strobe_d = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        cnt_en = 1'b1;
        busy_d = 1'b1;
        w_d    = w_q;
        if (tick) begin
          if (bits_q > 1) begin
            bits_d   = bits_q - 1'b1;
            sr_d     = sr_next;
            w_d      = sr_next[WIDTH-1];
            strobe_d = 1'b1;
          end else begin
            state_d = S_FINISH;
            bits_d  = '0;
            w_d     = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      bits_q   <= '0;
      div_q    <= '0;
      w_q      <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bits_q   <= bits_d;
      div_q    <= div_d;
      w_q      <= w_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sif.w          = w_q;
  assign sif.bit_strobe = strobe_q;
  assign sif.busy       = busy_q;
  assign sif.done       = done_q;

endmodule

// File: tb/tb_secuencia_generador.sv
// tb/tb_secuencia_generador.sv - directed bench for the serial pattern generator
module tb_secuencia_generador;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  secuencia_generador_if #(.WIDTH(8), .LEN_W(4), .DIV_W(16)) sif ();

  secuencia_generador #(.WIDTH(8), .LEN_W(4), .DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {w, bit_strobe, busy, done}.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check(tag, {sif.w, sif.bit_strobe, sif.busy, sif.done}, exp);
  endtask

  initial begin
    logic [7:0] pat;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    sif.start   = 1'b0;
    sif.pattern = '0;
    sif.len     = '0;
    sif.div     = '0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc("reset_state", 4'b0000);

    // Fast frame: 3'b110 at one bit per cycle.
    sif.pattern = 8'b0000_0110; sif.len = 4'd3; sif.div = 16'd0; sif.start = 1'b1;
    cyc("fast_c0", 4'b1110);
    sif.start = 1'b0;
    cyc("fast_c1", 4'b1110);
    cyc("fast_c2", 4'b0110);
    cyc("fast_done", 4'b0011);
    cyc("fast_idle", 4'b0000);

    // Slow frame: 8'hA5, each bit held three cycles.
    pat = 8'hA5;
    sif.pattern = pat; sif.len = 4'd8; sif.div = 16'd2; sif.start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc($sformatf("slow_c%0d", i), {pat[7 - i / 3], (i % 3) == 0, 1'b1, 1'b0});
      sif.start = 1'b0;
    end
    cyc("slow_done", 4'b0011);
    cyc("slow_idle", 4'b0000);

    // Zero length goes straight to the done cycle.
    sif.pattern = 8'hFF; sif.len = 4'd0; sif.div = 16'd5; sif.start = 1'b1;
    cyc("zero_done", 4'b0011);
    sif.start = 1'b0;
    cyc("zero_idle0", 4'b0000);
    cyc("zero_idle1", 4'b0000);

    // Length clamp plus operand capture; a mid-frame start is ignored.
    sif.pattern = 8'hFF; sif.len = 4'd15; sif.div = 16'd0; sif.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("clamp_c%0d", i), 4'b1110);
      sif.start = (i == 2);
      if (i == 2) begin
        sif.pattern = 8'h00; sif.len = 4'd3; sif.div = 16'd7;
      end
    end
    cyc("clamp_done", 4'b0011);
    cyc("clamp_idle0", 4'b0000);
    cyc("clamp_idle1", 4'b0000);

    // Start held high: identical frames separated by one idle cycle.
    sif.pattern = 8'b01; sif.len = 4'd2; sif.div = 16'd0; sif.start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cyc($sformatf("b2b%0d_bit1", f), 4'b0110);
      cyc($sformatf("b2b%0d_bit0", f), 4'b1110);
      cyc($sformatf("b2b%0d_done", f), 4'b0011);
      if (f == 1) sif.start = 1'b0;
      cyc($sformatf("b2b%0d_idle", f), 4'b0000);
    end
    cyc("b2b_quiet", 4'b0000);

    // Asynchronous reset mid-frame abandons it without a done pulse.
    sif.pattern = 8'hA5; sif.len = 4'd8; sif.div = 16'd2; sif.start = 1'b1;
    cyc("rst_mid_c0", 4'b1110);
    sif.start = 1'b0;
    cyc("rst_mid_c1", 4'b1010);
    cyc("rst_mid_c2", 4'b1010);
    cyc("rst_mid_c3", 4'b0110);
    #2 reset = 1'b0;
    #1 check("rst_async", {sif.w, sif.bit_strobe, sif.busy, sif.done}, 4'b0000);
    cyc("rst_hold", 4'b0000);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("rst_after%0d", i), 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
